// File: rtl/fa_pkg.sv
// fa_pkg: shared widths and mean extraction for the FA publisher.
package fa_pkg;
    localparam int SAMPLE_WIDTH = 26;
    localparam int GPIO_WIDTH   = 32;
    localparam int L2_DECIM_MAX = 10;
    localparam int ACC_WIDTH    = SAMPLE_WIDTH + L2_DECIM_MAX;

    // Arithmetic shift floors toward -inf; the mean always fits SAMPLE_WIDTH bits.
    function automatic logic signed [GPIO_WIDTH-1:0] fa_mean(
        input logic signed [ACC_WIDTH-1:0] acc,
        input logic [3:0] shift
    );
        logic signed [SAMPLE_WIDTH-1:0] m;
        m = SAMPLE_WIDTH'(acc >>> shift);
        return {{(GPIO_WIDTH - SAMPLE_WIDTH){m[SAMPLE_WIDTH-1]}}, m};
    endfunction
endpackage

// File: rtl/fa_publisher_if.sv
// fa_publisher_if: TbT input stream and FA output stream of the publisher.
interface fa_publisher_if #(
    parameter int GPIO_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 26
);
    logic [3:0]                     l2Decim;
    logic                           faSync;
    logic                           tbtValid;
    logic signed [SAMPLE_WIDTH-1:0] tbtX;
    logic signed [SAMPLE_WIDTH-1:0] tbtY;
    logic                           faToggle;
    logic [GPIO_WIDTH-1:0]          faX;
    logic [GPIO_WIDTH-1:0]          faY;
    logic [GPIO_WIDTH-1:0]          faCount;
    logic [15:0]                    syncErrors;

    modport master (
        output l2Decim, faSync, tbtValid, tbtX, tbtY,
        input  faToggle, faX, faY, faCount, syncErrors
    );
    modport slave (
        input  l2Decim, faSync, tbtValid, tbtX, tbtY,
        output faToggle, faX, faY, faCount, syncErrors
    );
endinterface

// File: rtl/fa_axis_accumulator.sv
// fa_axis_accumulator: one axis's window sum, captured final sum and published mean.
module fa_axis_accumulator
    import fa_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid,
    input  logic                           first,
    input  logic                           last,
    input  logic                           publish,
    input  logic [3:0]                     shift,
    input  logic signed [SAMPLE_WIDTH-1:0] sample,
    output logic signed [GPIO_WIDTH-1:0]   mean
);
    logic signed [ACC_WIDTH-1:0] acc, fin, sum;

    assign sum = (first ? '0 : acc) + {{L2_DECIM_MAX{sample[SAMPLE_WIDTH-1]}}, sample};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            fin  <= '0;
            mean <= '0;
        end else begin
            if (valid) acc <= sum;
            if (valid && last) fin <= sum;
            if (publish) mean <= fa_mean(fin, shift);
        end
    end
endmodule

// File: rtl/fa_publisher.sv
// fa_publisher: averages 2^L TbT samples per window and publishes the mean with a toggle strobe.
module fa_publisher #(
    parameter int GPIO_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 26
) (
    input logic           clk,
    input logic           rst_n,
    fa_publisher_if.slave bus
);
    logic [fa_pkg::L2_DECIM_MAX-1:0] n, n_cur, n_nxt;
    logic [3:0]  l_reg, l_in, l_eff, pend_shift;
    logic [10:0] lim;
    logic        first, last, pending;
    logic        fa_toggle;
    logic [GPIO_WIDTH-1:0] fa_count;
    logic [15:0] sync_errors;
    logic signed [fa_pkg::GPIO_WIDTH-1:0] mean_x, mean_y;

    // A sync restarts the count, so a coincident sample is sample 0 of the new window.
    always_comb begin
        l_in  = bus.l2Decim > 4'(fa_pkg::L2_DECIM_MAX) ? 4'(fa_pkg::L2_DECIM_MAX) : bus.l2Decim;
        n_cur = bus.faSync ? '0 : n;
        first = n_cur == '0;
        l_eff = first ? l_in : l_reg;
        lim   = (11'd1 << l_eff) - 11'd1;
        last  = bus.tbtValid && ({1'b0, n_cur} == lim);
        n_nxt = !bus.tbtValid ? n_cur : last ? '0 : n_cur + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n           <= '0;
            l_reg       <= '0;
            pending     <= 1'b0;
            pend_shift  <= '0;
            fa_toggle   <= 1'b0;
            fa_count    <= '0;
            sync_errors <= '0;
        end else begin
            n       <= n_nxt;
            pending <= last;
            if (bus.tbtValid && first) l_reg <= l_in;
            if (last) pend_shift <= l_eff;
            if (pending) begin
                fa_toggle <= ~fa_toggle;
                fa_count  <= fa_count + 1'b1;
            end
            if (bus.faSync && n != '0 && sync_errors != 16'hFFFF)
                sync_errors <= sync_errors + 16'd1;
        end
    end

    fa_axis_accumulator u_acc_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (bus.tbtValid),
        .first   (first),
        .last    (last),
        .publish (pending),
        .shift   (pend_shift),
        .sample  (bus.tbtX[SAMPLE_WIDTH-1:0]),
        .mean    (mean_x)
    );

    fa_axis_accumulator u_acc_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (bus.tbtValid),
        .first   (first),
        .last    (last),
        .publish (pending),
        .shift   (pend_shift),
        .sample  (bus.tbtY[SAMPLE_WIDTH-1:0]),
        .mean    (mean_y)
    );

    assign bus.faToggle   = fa_toggle;
    assign bus.faX        = GPIO_WIDTH'(mean_x);
    assign bus.faY        = GPIO_WIDTH'(mean_y);
    assign bus.faCount    = fa_count;
    assign bus.syncErrors = sync_errors;
endmodule

// File: tb/tb_fa_publisher.sv
// tb_fa_publisher: scoreboard bench comparing published FA means against a window-averaging model.
module tb_fa_publisher;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fa_publisher_if #(.GPIO_WIDTH(32), .SAMPLE_WIDTH(26)) bus ();
    fa_publisher #(.GPIO_WIDTH(32), .SAMPLE_WIDTH(26)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        longint x;
        longint y;
        longint cnt;
        longint when;
    } exp_t;

    exp_t   sb[$];
    longint wx[$], wy[$];
    int     wl = 0;
    int     pubs = 0;
    int     synce = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint floor_mean(input longint q[$], input int l);
        longint s = 0;
        longint d = longint'(1) << l;
        longint r;
        foreach (q[i]) s += q[i];
        r = s / d;
        if (s % d != 0 && s < 0) r = r - 1;
        return r;
    endfunction

    function automatic longint rnd26();
        logic signed [25:0] r;
        r = 26'($urandom);
        return longint'(r);
    endfunction

    task automatic model(input bit v, input bit s, input int l2, input longint x, input longint y);
        exp_t e;
        if (s) begin
            if (wx.size() != 0 && synce < 65535) synce++;
            wx.delete();
            wy.delete();
        end
        if (v) begin
            if (wx.size() == 0) wl = l2 > 10 ? 10 : l2;
            wx.push_back(x);
            wy.push_back(y);
            if (wx.size() == (1 << wl)) begin
                pubs++;
                e.x = floor_mean(wx, wl);
                e.y = floor_mean(wy, wl);
                e.cnt = pubs;
                e.when = cyc + 2;
                sb.push_back(e);
                wx.delete();
                wy.delete();
            end
        end
    endtask

    task automatic drive(input bit v, input bit s, input int l2, input longint x, input longint y);
        @(negedge clk);
        bus.tbtValid = v;
        bus.faSync   = s;
        bus.l2Decim  = 4'(l2);
        bus.tbtX     = 26'(x);
        bus.tbtY     = 26'(y);
        model(v, s, l2, x, y);
    endtask

    task automatic idle(input int k, input int l2);
        for (int i = 0; i < k; i++) drive(0, 0, l2, 0, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_toggle"}, longint'(bus.faToggle), 0);
        chk({tag, "_faX"}, longint'(bus.faX), 0);
        chk({tag, "_faY"}, longint'(bus.faY), 0);
        chk({tag, "_count"}, longint'(bus.faCount), 0);
        chk({tag, "_syncerr"}, longint'(bus.syncErrors), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.tbtValid = 1'b0;
        bus.faSync = 1'b0;
        sb.delete();
        wx.delete();
        wy.delete();
        pubs = 0;
        synce = 0;
        @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
    endtask

    // Monitor: every toggle edge must match the oldest expected publish.
    initial begin
        automatic bit prev = 1'b0;
        automatic exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) prev = bus.faToggle;
            else if (bus.faToggle !== prev) begin
                prev = bus.faToggle;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_publish: got toggle at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("faX", longint'($signed(bus.faX)), e.x);
                    chk("faY", longint'($signed(bus.faY)), e.y);
                    chk("faCount", longint'(bus.faCount), e.cnt);
                    chk("publish_cycle", longint'(cyc), e.when);
                end
            end
        end
    end

    initial begin
        int l2;
        bus.tbtValid = 1'b0;
        bus.faSync   = 1'b0;
        bus.l2Decim  = 4'd0;
        bus.tbtX     = '0;
        bus.tbtY     = '0;
        repeat (3) @(negedge clk);
        chk_zero("init");
        rst_n = 1'b1;
        idle(2, 2);

        // mean of 4,8,12,16 is 10
        for (int i = 1; i <= 4; i++) drive(1, 0, 2, 4 * i, rnd26());
        idle(3, 2);
        chk("first_toggle", longint'(bus.faToggle), 1);
        chk("first_faX", longint'(bus.faX), 10);

        // negative floor and full-scale positive without overflow
        drive(1, 0, 1, 7, -3);
        drive(1, 0, 1, 9, -4);
        idle(3, 1);
        chk("neg_floor_faY", longint'(bus.faY), 64'hFFFFFFFC);
        drive(1, 0, 1, -33554432, 33554431);
        drive(1, 0, 1, -33554432, 33554431);
        idle(3, 1);
        chk("max_faY", longint'(bus.faY), 64'h01FFFFFF);
        chk("min_faX", longint'(bus.faX), 64'hFE000000);

        // L=0 ramp, one publish per cycle
        for (int i = 1; i <= 8; i++) drive(1, 0, 0, i, -i);
        idle(3, 0);

        // sync mid-window discards it, sync at n=0 does not count
        for (int i = 0; i < 5; i++) drive(1, 0, 3, rnd26(), rnd26());
        drive(0, 1, 3, 0, 0);
        idle(2, 3);
        chk("sync_err_mid", longint'(bus.syncErrors), longint'(synce));
        for (int i = 0; i < 8; i++) drive(1, 0, 3, rnd26(), rnd26());
        idle(3, 3);
        drive(0, 1, 3, 0, 0);
        idle(2, 3);
        chk("sync_err_idle", longint'(bus.syncErrors), longint'(synce));
        // sync coinciding with a sample
        for (int i = 0; i < 3; i++) drive(1, 0, 1, rnd26(), rnd26());
        drive(1, 1, 2, rnd26(), rnd26());
        for (int i = 0; i < 3; i++) drive(1, 0, 2, rnd26(), rnd26());
        idle(3, 2);

        // l2Decim change mid-window
        drive(1, 0, 2, rnd26(), rnd26());
        for (int i = 0; i < 3; i++) drive(1, 0, 4, rnd26(), rnd26());
        for (int i = 0; i < 16; i++) drive(1, 0, 4, rnd26(), rnd26());
        idle(3, 4);

        // reset while a publish is pending
        drive(1, 0, 0, 5, 5);
        do_reset();
        idle(3, 1);
        chk_zero("post_reset");
        drive(1, 0, 1, 100, -100);
        drive(1, 0, 1, 101, -101);
        idle(3, 1);
        chk("reset_window_toggle", longint'(bus.faToggle), 1);

        // randomized traffic
        l2 = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 5))
                    0: l2 = 0;
                    1: l2 = 1;
                    2: l2 = 2;
                    3: l2 = 3;
                    4: l2 = 4;
                    default: l2 = 13;
                endcase
            end
            drive(bit'($urandom_range(0, 1)), $urandom_range(0, 49) == 0, l2, rnd26(), rnd26());
        end
        idle(20, l2);

        chk("scoreboard_drained", longint'(sb.size()), 0);
        chk("final_count", longint'(bus.faCount), longint'(pubs));
        chk("final_sync_errors", longint'(bus.syncErrors), longint'(synce));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fa_publisher.md
# fa_publisher

Produces the fast-acquisition (FA) position stream consumed by the RMS calculator and other FA readers. It accumulates 2^l2Decim turn-by-turn (TbT) X/Y position samples per window and publishes their arithmetic mean on faX/faY. It signals each new value by inverting faToggle, with the data stable no later than the toggle edge. It sits between the TbT position calculator and all FA consumers; faSync aligns window boundaries to the machine timing system.

## Interface
Parameters:
- GPIO_WIDTH, 32: width of published FA words and counters.
- SAMPLE_WIDTH, 26: meaningful signed bits in TbT inputs and FA outputs.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low; one clock domain.
- l2Decim  in  4  log2 of samples per window; values above 10 are treated as 10; sampled only at window start.
- faSync  in  1  single-cycle pulse; restarts the window.
- tbtValid  in  1  single-cycle strobe qualifying tbtX/tbtY; may be asserted on consecutive cycles.
- tbtX, tbtY  in  SAMPLE_WIDTH  signed TbT positions.
- faToggle  out  1  inverts once per published value.
- faX, faY  out  GPIO_WIDTH  signed mean, sign-extended from SAMPLE_WIDTH.
- faCount  out  GPIO_WIDTH  number of published values; wraps modulo 2^GPIO_WIDTH.
- syncErrors  out  16  count of faSync pulses arriving mid-window; saturates at 0xFFFF.

## Operation
- Reset values: faToggle=0, faX=0, faY=0, faCount=0, syncErrors=0, sample count=0, accumulators=0, pending=0.
- State is the sample count n within the current window (0..2^L-1), where L is latched from min(l2Decim,10) when n=0 and a sample is accepted.
- Accumulators are signed, SAMPLE_WIDTH+10 bits, so no overflow is possible.
- Accepted sample with n=0: acc <= sample. With n>0: acc <= acc + sample.
- Last sample of the window (n=2^L-1, including L=0 where every sample is last):
  - final <= acc + sample (or the sample alone if L=0).
  - pending <= 1.
  - n <= 0.
- pending=1 causes, on the next cycle:
  - faX/faY <= sign-extend(final >>> L), arithmetic shift, truncating toward −∞.
  - faToggle inverts.
  - faCount increments.
  - pending <= 0.
- X and Y always share n, L, and publish timing.
- faSync:
  - Discards the partial window: n <= 0. An already-pending publish still completes.
  - Increments syncErrors (saturating) if n≠0 when it arrives.
  - If faSync coincides with tbtValid, that sample becomes sample 0 of the new window and L is latched from the current l2Decim.
- A change to l2Decim mid-window has no effect until the next window start.

## Timing
- Last sample at cycle t: faX/faY/faToggle/faCount all change at t+2, in the same cycle. Readers detecting the toggle edge at t+3 therefore see stable data.
- Back-to-back windows (L=0, tbtValid every cycle): one publish per cycle at t+2, t+3, …. The pending/final path is fully pipelined, with no stalls and no dropped samples.
- No back-pressure: tbtValid is always accepted.
- rst_n asserted mid-window or mid-publish: all state clears immediately (asynchronously). The pending publish is lost and faToggle returns to 0.
- rst_n deassertion takes effect on the next clk edge. The first tbtValid after reset starts a window.

## Structure
- Package fa_pkg holds:
  - SAMPLE_WIDTH.
  - L2_DECIM_MAX=10.
  - ACC_WIDTH=SAMPLE_WIDTH+L2_DECIM_MAX.
  - The mean-extraction function (shift plus sign-extend).
- One sub-module, fa_axis_accumulator:
  - Holds one axis's acc/final registers.
  - Inputs: sample, first, last, shift.
  - Output: registered mean.
  - Instantiated twice (X, Y).
- The top level owns n, L, pending, faToggle, faCount, syncErrors, and faSync handling.

## Test plan
- Reset, l2Decim=2, tbtX = 4,8,12,16 on consecutive cycles -> faX=10 at 2 cycles after the 4th strobe; faToggle 0->1; faCount=1.
- l2Decim=1, tbtY = −3,−4 -> faY = 0xFFFFFFFC (−4, floor of −3.5); tbtY = 0x1FFFFFF,0x1FFFFFF -> faY = 0x01FFFFFF (no overflow).
- l2Decim=0, tbtValid every cycle for 8 cycles, ramp 1..8 -> 8 toggles on consecutive cycles, faX follows the ramp delayed by 2 cycles, faCount=8.
- l2Decim=3, faSync after 5 samples -> no publish, syncErrors=1. Next 8 samples publish their mean. faSync at n=0 -> syncErrors unchanged.
- l2Decim changed from 2 to 4 after sample 1 -> current window still closes after 4 samples; the next window uses 16.
- rst_n pulsed 1 cycle after the last sample (pending=1) -> no toggle; all outputs 0. The next full window publishes normally with faToggle=1.
